// File: rtl/player_shot_pkg.sv
// Shared types and fixed-point helpers for the player shot pool.
package player_shot_pkg;
    localparam int DEF_FRAC_BITS          = 6;
    localparam int FIXED_POINT_MULTIPLIER = 1 << DEF_FRAC_BITS;

    typedef logic signed [31:0] pos_fp_t;
    typedef logic signed [10:0] pix_t;

    typedef enum logic {SLOT_IDLE, SLOT_FLYING} slot_state_e;

    // Floor to whole pixels, then keep the low 11 bits.
    function automatic pix_t fp_to_pix(pos_fp_t v, int frac);
        pos_fp_t s;
        s = v >>> frac;
        return pix_t'(s[10:0]);
    endfunction
endpackage

// File: rtl/player_shot_pool_if.sv
// Control/status bundle between the shot pool and its neighbours.
interface player_shot_pool_if
    import player_shot_pkg::*;
#(
    parameter int NUM_SHOTS = 3
);
    localparam int CNTW = $clog2(NUM_SHOTS + 1);

    logic                    playGame;
    logic                    startOfFrame;
    logic                    fire;
    pix_t                    playerXPosition;
    logic [NUM_SHOTS-1:0]    fireCollision;
    logic [NUM_SHOTS*11-1:0] topLeftX;
    logic [NUM_SHOTS*11-1:0] topLeftY;
    logic [NUM_SHOTS-1:0]    alive;
    logic                    newFire;
    logic [CNTW-1:0]         activeCount;

    modport master (
        output playGame, startOfFrame, fire, playerXPosition, fireCollision,
        input  topLeftX, topLeftY, alive, newFire, activeCount
    );
    modport slave (
        input  playGame, startOfFrame, fire, playerXPosition, fireCollision,
        output topLeftX, topLeftY, alive, newFire, activeCount
    );
endinterface

// File: rtl/player_shot_slot.sv
// One shot slot: IDLE/FLYING FSM, fixed-point position, optional frame age.
// Age limiting is compiled in with PLAYER_SHOT_LIFETIME_EN.
module player_shot_slot
    import player_shot_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int INITIAL_Y = 400,
    parameter int Y_SPEED   = -320,
    parameter int TOP_LIMIT = 0,
    parameter int MAX_LIFE  = 100
) (
    input  logic    clk,
    input  logic    resetN,
    input  logic    clear_i,
    input  logic    sof_i,
    input  logic    launch_i,
    input  logic    collide_i,
    input  pos_fp_t launch_x_i,
    output logic    alive_o,
    output pix_t    x_pix_o,
    output pix_t    y_pix_o
);
    localparam pos_fp_t Y_INIT = pos_fp_t'(INITIAL_Y) <<< FRAC_BITS;

    slot_state_e state_q, state_d;
    pos_fp_t     x_q, x_d, y_q, y_d, y_step;

`ifdef PLAYER_SHOT_LIFETIME_EN
    localparam int AW = $clog2(MAX_LIFE + 1);
    logic [AW-1:0] age_q, age_d;
`else
    logic unused_life;
    assign unused_life = (MAX_LIFE > 0);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        y_step  = y_q + pos_fp_t'(Y_SPEED);
`ifdef PLAYER_SHOT_LIFETIME_EN
        age_d   = age_q;
`endif
        if (clear_i) begin
            state_d = SLOT_IDLE;
            x_d     = '0;
            y_d     = Y_INIT;
`ifdef PLAYER_SHOT_LIFETIME_EN
            age_d   = '0;
`endif
        end else if (launch_i && state_q == SLOT_IDLE) begin
            // A launch swallows any collision and any frame tick this clk.
            state_d = SLOT_FLYING;
            x_d     = launch_x_i;
            y_d     = Y_INIT;
`ifdef PLAYER_SHOT_LIFETIME_EN
            age_d   = '0;
`endif
        end else if (state_q == SLOT_FLYING) begin
            if (collide_i) begin
                state_d = SLOT_IDLE;
            end else if (sof_i) begin
                y_d = y_step;
                if (int'(fp_to_pix(y_step, FRAC_BITS)) < TOP_LIMIT)
                    state_d = SLOT_IDLE;
`ifdef PLAYER_SHOT_LIFETIME_EN
                age_d = age_q + AW'(1);
                if (age_d >= AW'(MAX_LIFE))
                    state_d = SLOT_IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= SLOT_IDLE;
            x_q     <= '0;
            y_q     <= Y_INIT;
`ifdef PLAYER_SHOT_LIFETIME_EN
            age_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
`ifdef PLAYER_SHOT_LIFETIME_EN
            age_q   <= age_d;
`endif
        end
    end

    assign alive_o = (state_q == SLOT_FLYING);
    assign x_pix_o = fp_to_pix(x_q, FRAC_BITS);
    assign y_pix_o = fp_to_pix(y_q, FRAC_BITS);
endmodule

// File: rtl/player_shot_pool.sv
// Multi-slot player shot manager: allocation, cooldown and launch pulse.
// Optional per-shot lifetime under PLAYER_SHOT_LIFETIME_EN.
module player_shot_pool
    import player_shot_pkg::*;
#(
    parameter int NUM_SHOTS       = 3,
    parameter int FRAC_BITS       = DEF_FRAC_BITS,
    parameter int INITIAL_Y       = 400,
    parameter int X_OFFSET        = 32,
    parameter int Y_SPEED         = -320,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int TOP_LIMIT       = 0,
    parameter int MAX_LIFE        = 100
) (
    input logic               clk,
    input logic               resetN,
    player_shot_pool_if.slave bus
);
    localparam int CW   = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam int CNTW = $clog2(NUM_SHOTS + 1);

    logic [NUM_SHOTS-1:0]  alive, grant;
    pix_t [NUM_SHOTS-1:0]  x_pix, y_pix;
    logic [CW-1:0]         cool_q, cool_d;
    logic                  new_fire_q, launch, found;
    logic [CNTW-1:0]       count;
    pos_fp_t               launch_x;

    // Lowest-index idle slot wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!alive[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign launch   = bus.playGame && bus.fire && (cool_q == '0) && found;
    assign launch_x = (pos_fp_t'(bus.playerXPosition) + pos_fp_t'(X_OFFSET)) <<< FRAC_BITS;

    always_comb begin
        cool_d = cool_q;
        if (!bus.playGame)
            cool_d = '0;
        else if (launch)
            cool_d = CW'(COOLDOWN_FRAMES);
        else if (bus.startOfFrame && cool_q != '0)
            cool_d = cool_q - CW'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cool_q     <= '0;
            new_fire_q <= 1'b0;
        end else begin
            cool_q     <= cool_d;
            new_fire_q <= launch;
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        player_shot_slot #(
            .FRAC_BITS (FRAC_BITS),
            .INITIAL_Y (INITIAL_Y),
            .Y_SPEED   (Y_SPEED),
            .TOP_LIMIT (TOP_LIMIT),
            .MAX_LIFE  (MAX_LIFE)
        ) u_slot (
            .clk        (clk),
            .resetN     (resetN),
            .clear_i    (!bus.playGame),
            .sof_i      (bus.startOfFrame),
            .launch_i   (launch && grant[g]),
            .collide_i  (bus.fireCollision[g]),
            .launch_x_i (launch_x),
            .alive_o    (alive[g]),
            .x_pix_o    (x_pix[g]),
            .y_pix_o    (y_pix[g])
        );
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_SHOTS; i++)
            count = count + CNTW'(alive[i]);
    end

    assign bus.topLeftX    = x_pix;
    assign bus.topLeftY    = y_pix;
    assign bus.alive       = alive;
    assign bus.newFire     = new_fire_q;
    assign bus.activeCount = count;
endmodule

// File: tb/tb_player_shot_pool.sv
// Scoreboard bench for player_shot_pool; expectations queued at drive time.
module tb_player_shot_pool;
    import player_shot_pkg::*;

    localparam int NS = 3;
`ifdef PLAYER_SHOT_LIFETIME_EN
    localparam int YS = -64;
    localparam int ML = 10;
`else
    localparam int YS = -320;
    localparam int ML = 100;
`endif
    // observable selectors
    localparam int S_ALIVE = 0, S_X = 10, S_Y = 20, S_NF = 30, S_CNT = 31, S_AV = 40;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;
    exp_t sb[$];

    player_shot_pool_if #(.NUM_SHOTS(NS)) bus();

    player_shot_pool #(
        .NUM_SHOTS(NS), .Y_SPEED(YS), .MAX_LIFE(ML)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish (got running, want done)");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int observe(input int sel);
        logic [10:0] raw;
        if (sel == S_AV)  return int'(bus.alive);
        if (sel == S_NF)  return int'(bus.newFire);
        if (sel == S_CNT) return int'(bus.activeCount);
        if (sel >= S_Y) begin
            raw = bus.topLeftY[11*(sel-S_Y) +: 11];
            return int'($signed(raw));
        end
        if (sel >= S_X) begin
            raw = bus.topLeftX[11*(sel-S_X) +: 11];
            return int'($signed(raw));
        end
        return int'(bus.alive[sel]);
    endfunction

    task automatic want(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    initial begin
        bus.playGame        = 1'b0;
        bus.startOfFrame    = 1'b0;
        bus.fire            = 1'b0;
        bus.playerXPosition = 11'sd100;
        bus.fireCollision   = '0;
        want("rst_alive", S_AV, 0);
        want("rst_cnt", S_CNT, 0);
        want("rst_nf", S_NF, 0);
        want("rst_y0", S_Y + 0, 400);
        want("rst_x0", S_X + 0, 0);
        tick();
        resetN = 1'b1;
        bus.playGame = 1'b1;
        tick();

`ifdef PLAYER_SHOT_LIFETIME_EN
        bus.fire = 1'b1;
        want("life_launch", S_AV, 1);
        tick();
        bus.fire = 1'b0;
        for (int f = 1; f <= 9; f++) frame();
        want("life_f9_alive", S_AV, 1);
        want("life_f9_y", S_Y + 0, 391);
        drain();
        want("life_f10_alive", S_AV, 0);
        want("life_f10_y", S_Y + 0, 390);
        frame();
`else
        // single launch and flight to the top
        bus.fire = 1'b1;
        want("l1_alive", S_AV, 1);
        want("l1_x", S_X + 0, 132);
        want("l1_y", S_Y + 0, 400);
        want("l1_nf", S_NF, 1);
        tick();
        bus.fire = 1'b0;
        want("l1_nf_off", S_NF, 0);
        tick();
        want("f1_y", S_Y + 0, 395);
        frame();
        for (int f = 2; f <= 79; f++) frame();
        want("f80_y", S_Y + 0, 0);
        want("f80_alive", S_AV, 1);
        frame();
        want("f81_alive", S_AV, 0);
        want("f81_cnt", S_CNT, 0);
        frame();

        // held fire: launches every 8 frames until slots run out
        bus.fire = 1'b1;
        want("h0_nf", S_NF, 1);
        want("h0_alive", S_AV, 1);
        tick();
        for (int f = 1; f <= 24; f++) begin
            want($sformatf("h%0d_nf", f), S_NF, (f == 8 || f == 16) ? 1 : 0);
            want($sformatf("h%0d_cnt", f), S_CNT, (f < 8) ? 1 : (f < 16) ? 2 : 3);
            frame();
        end
        want("h_y0", S_Y + 0, 280);
        want("h_y1", S_Y + 1, 320);
        want("h_y2", S_Y + 2, 360);
        drain();
        bus.fire = 1'b0;
        tick();

        // collision frees slot1, next launch reuses it
        bus.fireCollision = 3'b010;
        want("col_alive", S_AV, 3'b101);
        want("col_cnt", S_CNT, 2);
        tick();
        bus.fireCollision = '0;
        bus.fire = 1'b1;
        want("reuse_alive", S_AV, 3'b111);
        want("reuse_nf", S_NF, 1);
        want("reuse_y1", S_Y + 1, 400);
        want("reuse_x1", S_X + 1, 132);
        tick();
        bus.fire = 1'b0;
        tick();

        // launch + frame + collision on the chosen slot in one clk
        bus.fireCollision = 3'b100;
        want("col2_alive", S_AV, 3'b011);
        tick();
        bus.fireCollision = '0;
        for (int f = 0; f < 8; f++) frame();
        bus.fire = 1'b1;
        bus.startOfFrame = 1'b1;
        bus.fireCollision = 3'b100;
        want("sim_alive", S_AV, 3'b111);
        want("sim_nf", S_NF, 1);
        want("sim_y2", S_Y + 2, 400);
        want("sim_y1", S_Y + 1, 355);
        tick();
        bus.fire = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.fireCollision = '0;
        want("sim_y2_hold", S_Y + 2, 400);
        tick();
        want("sim_y2_next", S_Y + 2, 395);
        frame();

        // synchronous clear, then immediate fire
        bus.playGame = 1'b0;
        want("clr_alive", S_AV, 0);
        want("clr_cnt", S_CNT, 0);
        want("clr_y0", S_Y + 0, 400);
        want("clr_x0", S_X + 0, 0);
        tick();
        bus.playGame = 1'b1;
        bus.fire = 1'b1;
        bus.playerXPosition = -11'sd20;
        want("clr_fire_alive", S_AV, 1);
        want("clr_fire_nf", S_NF, 1);
        want("clr_fire_x0", S_X + 0, 12);
        tick();
        bus.fire = 1'b0;
        tick();

        // async reset between edges
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        want("arst_alive", S_AV, 0);
        want("arst_cnt", S_CNT, 0);
        want("arst_y0", S_Y + 0, 400);
        drain();
        tick();
        resetN = 1'b1;
        tick();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
